mul_booth_seq: RTL and testbench
================================

Name: mul_booth_seq

Overview:
- Iterative radix-4 Booth multiply sequencer for the RV64 M-extension multiply path.
- Accepts one multiply request at a time from execute and runs one Booth step per cycle.
- Each step uses an external combinational parallel-prefix adder, built from black/grey cells.
- Returns the selected product half over a valid/ready response channel.

Parameters:
- XLEN, 64, operand/result width.
- AW, XLEN+4, width of the external prefix adder operands.
- TAGW, 5, width of the destination tag carried through.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  abort in-flight operation (pipeline kill)
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- req_word  in  1  MULW (32-bit op; only valid with req_op=00)
- req_rs1  in  XLEN  multiplicand
- req_rs2  in  XLEN  multiplier
- req_tag  in  TAGW  destination tag
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  XLEN  result
- resp_tag  out  TAGW  tag of result
- add_a  out  AW  adder operand A (accumulator high part)
- add_b  out  AW  adder operand B (Booth partial product, inverted for negative)
- add_cin  out  1  adder carry-in (1 for negative partial product)
- add_sum  in  AW  adder result, same cycle
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous) values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_tag=0, busy=0. The add_* outputs are 0 while IDLE.
- FSM states: IDLE, CALC, DONE.
  - IDLE→CALC on req_valid&&req_ready.
  - CALC→DONE when the iteration counter reaches its last value.
  - DONE→IDLE on resp_valid&&resp_ready.
- req_ready=1 only in IDLE. No request is accepted in DONE, even if the response drains that same cycle.
- Operand extension at accept, to XLEN+2 bits (even width):
  - rs1 is sign-extended for MULH/MULHSU and zero-extended for MULHU/MUL.
  - rs2 is sign-extended for MULH and zero-extended for MULHSU/MULHU/MUL.
  - Word op: both operands are taken from bits[31:0] and sign-extended.
- Iteration count N:
  - Full ops: N=(XLEN+2)/2=33.
  - Word: N=17.
  - Counter loads N-1 at accept and decrements once per CALC cycle.
- Each CALC cycle:
  - Inspect Booth triplet {Q[1:0],q_-1}.
  - Select pp ∈ {0,+M,+2M,-M,-2M}, sign-extended to AW.
  - Negative pp: add_b=~pp, add_cin=1.
  - Accumulator := add_sum, then the {acc,Q} pair is shifted arithmetically right by 2.
- Zero fast path: if either extended operand is 0 at accept, skip CALC and go directly to DONE with result 0 (latency 1).
- Result selection on CALC→DONE:
  - MUL: low XLEN bits of the product.
  - MULH*: bits[2XLEN-1:XLEN].
  - Word: product[31:0] sign-extended to XLEN.
- Latency from the accept edge to resp_valid high:
  - N+1 cycles normally (34 full, 18 word).
  - 1 cycle on the zero fast path.
- Response: resp_data/resp_tag are stable while resp_valid=1 && resp_ready=0.
- flush:
  - In CALC: return to IDLE next edge, no response.
  - In DONE: drop the response, go to IDLE.
  - In IDLE: flush wins over a simultaneous req_valid; nothing is accepted.
- Reset mid-operation: immediately return to reset values; the partial accumulator is discarded.
- Undefined req_word with req_op≠00: treated as MUL word.

Decomposition:
- Shared package: op encodings (MUL/MULH/MULHSU/MULHU), FSM state encoding, Booth select encoding, ITER_FULL=33, ITER_WORD=17.
- One natural sub-module, booth_pp_sel: combinational triplet → partial product, invert and carry-in.
- The prefix adder stays outside and is connected at the parent level.

Test Plan:
- MUL rs1=3, rs2=0xFFFF_FFFF_FFFF_FFFB (-5) → resp_data=0xFFFF_FFFF_FFFF_FFF1, resp_valid exactly 34 cycles after accept.
- MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE; MULH same operands → 0x0.
- MULHSU rs1=-1, rs2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFF; MULW 0x7FFF_FFFF×2 → 0xFFFF_FFFF_FFFF_FFFE after 18 cycles.
- Zero fast path: rs2=0, any op → resp_data=0, resp_valid 1 cycle after accept. resp_ready held low 5 cycles → data/tag stable, req_ready=0 throughout.
- flush asserted at CALC cycle 10 → no resp_valid, req_ready=1 next cycle. A following MUL 7×6 → 42 with its own tag.
- rst pulsed mid-CALC (asynchronous, between edges) → resp_valid=0 and req_ready=1 immediately, busy=0. A subsequent MUL completes correctly.

Source files
------------

// File: rtl/mul_booth_seq_pkg.sv
// Shared encodings for the radix-4 Booth multiply sequencer:
// op codes, FSM states, Booth select codes and iteration counts.
package mul_booth_seq_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_POS1 = 3'd1,
    SEL_POS2 = 3'd2,
    SEL_NEG1 = 3'd3,
    SEL_NEG2 = 3'd4
  } booth_sel_e;

  localparam int ITER_FULL = 33;
  localparam int ITER_WORD = 17;
  localparam int CNT_W     = 6;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ITER_FULL - 1);
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(ITER_WORD - 1);

  // Triplet is {q[i+1], q[i], q[i-1]} of the multiplier.
  function automatic booth_sel_e booth_decode(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: return SEL_POS1;
      3'b011:         return SEL_POS2;
      3'b100:         return SEL_NEG2;
      3'b101, 3'b110: return SEL_NEG1;
      default:        return SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/mul_booth_seq_pp_sel.sv
// Booth partial-product selector: maps a multiplier triplet to the adder
// B operand (one's complement for negative multiples) plus carry-in.
module booth_pp_sel
  import mul_booth_seq_pkg::*;
#(
  parameter int MW = 66,
  parameter int AW = 68
) (
  input  logic [2:0]    trip,
  input  logic [MW-1:0] m,
  output logic [AW-1:0] pp_b,
  output logic          cin
);

  logic [AW-1:0] m_ext;
  booth_sel_e    sel;

  assign m_ext = {{(AW-MW){m[MW-1]}}, m};
  assign sel   = booth_decode(trip);

  // Negation is completed by the adder through cin, keeping this path a pure mux.
  always_comb begin
    pp_b = '0;
    cin  = 1'b0;
    case (sel)
      SEL_POS1: pp_b = m_ext;
      SEL_POS2: pp_b = m_ext << 1;
      SEL_NEG1: begin
        pp_b = ~m_ext;
        cin  = 1'b1;
      end
      SEL_NEG2: begin
        pp_b = ~(m_ext << 1);
        cin  = 1'b1;
      end
      default: pp_b = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiply sequencer for the RV64 M-extension.
// One Booth step per cycle through an external prefix adder.
module mul_booth_seq
  import mul_booth_seq_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = XLEN + 4,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [TAGW-1:0] req_tag,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [TAGW-1:0] resp_tag,
  output logic [AW-1:0]   add_a,
  output logic [AW-1:0]   add_b,
  output logic            add_cin,
  input  logic [AW-1:0]   add_sum,
  output logic            busy
);

  localparam int EW  = XLEN + 2;
  localparam int WLO = EW - 2 * ITER_WORD;

  state_e           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [AW-1:0]    acc_reg;
  logic [EW-1:0]    q_reg;
  logic [EW-1:0]    m_reg;
  logic             qm1_reg;
  logic [1:0]       op_reg;
  logic             word_reg;
  logic [TAGW-1:0]  tag_reg;
  logic             req_ready_reg;
  logic             resp_valid_reg;
  logic [XLEN-1:0]  resp_data_reg;
  logic [TAGW-1:0]  resp_tag_reg;
  logic             busy_reg;

  logic [EW-1:0]    rs1_ext;
  logic [EW-1:0]    rs2_ext;
  logic [AW-1:0]    pp_b;
  logic             pp_cin;
  logic             calc;
  logic [AW-1:0]    acc_next;
  logic [EW-1:0]    q_next;
  logic [XLEN-1:0]  result;

  // Word ops ignore req_op and always sign-extend the low halves.
  always_comb begin
    if (req_word) begin
      rs1_ext = {{(EW-32){req_rs1[31]}}, req_rs1[31:0]};
      rs2_ext = {{(EW-32){req_rs2[31]}}, req_rs2[31:0]};
    end else begin
      rs1_ext = (req_op == OP_MULH || req_op == OP_MULHSU) ?
                {{(EW-XLEN){req_rs1[XLEN-1]}}, req_rs1} : {{(EW-XLEN){1'b0}}, req_rs1};
      rs2_ext = (req_op == OP_MULH) ?
                {{(EW-XLEN){req_rs2[XLEN-1]}}, req_rs2} : {{(EW-XLEN){1'b0}}, req_rs2};
    end
  end

  booth_pp_sel #(.MW(EW), .AW(AW)) u_pp_sel (
    .trip (({q_reg[1:0], qm1_reg})),
    .m    (m_reg),
    .pp_b (pp_b),
    .cin  (pp_cin)
  );

  assign calc    = (state_reg == ST_CALC);
  assign add_a   = calc ? acc_reg : '0;
  assign add_b   = calc ? pp_b : '0;
  assign add_cin = calc & pp_cin;

  // {acc,Q} shifts right by two after each add; product ends up as {acc,Q}.
  assign acc_next = {{2{add_sum[AW-1]}}, add_sum[AW-1:2]};
  assign q_next   = {add_sum[1:0], q_reg[EW-1:2]};

  always_comb begin
    if (word_reg)
      result = {{(XLEN-32){q_next[WLO+31]}}, q_next[WLO+31:WLO]};
    else if (op_reg == OP_MUL)
      result = q_next[XLEN-1:0];
    else
      result = {acc_next[XLEN-3:0], q_next[EW-1:XLEN]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      acc_reg        <= '0;
      q_reg          <= '0;
      m_reg          <= '0;
      qm1_reg        <= 1'b0;
      op_reg         <= '0;
      word_reg       <= 1'b0;
      tag_reg        <= '0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_tag_reg   <= '0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            op_reg        <= req_op;
            word_reg      <= req_word;
            tag_reg       <= req_tag;
            m_reg         <= rs1_ext;
            q_reg         <= rs2_ext;
            qm1_reg       <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= req_word ? CNT_WORD : CNT_FULL;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (rs1_ext == '0 || rs2_ext == '0) begin
              state_reg      <= ST_DONE;
              resp_valid_reg <= 1'b1;
              resp_data_reg  <= '0;
              resp_tag_reg   <= req_tag;
            end else begin
              state_reg <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end else begin
            acc_reg <= acc_next;
            q_reg   <= q_next;
            qm1_reg <= q_reg[1];
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == '0) begin
              state_reg      <= ST_DONE;
              resp_valid_reg <= 1'b1;
              resp_data_reg  <= result;
              resp_tag_reg   <= tag_reg;
            end
          end
        end
        ST_DONE: begin
          if (flush || resp_ready) begin
            state_reg      <= ST_IDLE;
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
          end
        end
        default: begin
          state_reg      <= ST_IDLE;
          resp_valid_reg <= 1'b0;
          req_ready_reg  <= 1'b1;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign resp_tag   = resp_tag_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Bench for mul_booth_seq: scoreboard of model results checked by an
// independent response monitor; models the external adder as plain addition.
module tb_mul_booth_seq;

  localparam int XLEN = 64;
  localparam int AW   = XLEN + 4;
  localparam int TAGW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      req_op = '0;
  logic            req_word = 1'b0;
  logic [XLEN-1:0] req_rs1 = '0;
  logic [XLEN-1:0] req_rs2 = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_data;
  logic [TAGW-1:0] resp_tag;
  logic [AW-1:0]   add_a;
  logic [AW-1:0]   add_b;
  logic            add_cin;
  logic [AW-1:0]   add_sum;
  logic            busy;

  typedef struct {
    logic [XLEN-1:0] data;
    logic [TAGW-1:0] tag;
    int              lat;
    int              acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  mul_booth_seq #(.XLEN(XLEN), .AW(AW), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_word   (req_word),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .busy       (busy)
  );

  assign add_sum = add_a + add_b + {{(AW-1){1'b0}}, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Full-width product from the ISA definition of each op.
  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic w,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] x, y, p;
    if (w) begin
      x = {{(2*XLEN-32){a[31]}}, a[31:0]};
      y = {{(2*XLEN-32){b[31]}}, b[31:0]};
      p = x * y;
      return {{(XLEN-32){p[31]}}, p[31:0]};
    end
    x = (op == 2'b01 || op == 2'b10) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    y = (op == 2'b01) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    p = x * y;
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic int ref_lat(input logic w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (w) return (a[31:0] == 32'd0 || b[31:0] == 32'd0) ? 1 : 18;
    return (a == '0 || b == '0) ? 1 : 34;
  endfunction

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(XLEN-1){1'b0}}};
      3:       return {{(XLEN-1){1'b0}}, 1'b1};
      4:       return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: captures first-valid cycle, checks hold stability, pops on handshake.
  exp_t            mon_e;
  int              vstart = 0;
  logic            prev_v = 1'b0;
  logic [XLEN-1:0] hold_d = '0;
  logic [TAGW-1:0] hold_t = '0;

  always @(negedge clk) begin
    if (resp_valid && !rst) begin
      if (!prev_v) begin
        vstart = cyc;
        hold_d = resp_data;
        hold_t = resp_tag;
      end else begin
        chk("stable_data", resp_data, hold_d);
        chk("stable_tag", XLEN'(resp_tag), XLEN'(hold_t));
      end
      chk("req_ready_done", XLEN'(req_ready), '0);
      if (resp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got tag %0d data %h, required none", resp_tag, resp_data);
        end else begin
          mon_e = sb.pop_front();
          $display("resp tag=%0d data=%h latency=%0d", resp_tag, resp_data, vstart - mon_e.acc_cyc);
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_tag", XLEN'(resp_tag), XLEN'(mon_e.tag));
          chk("latency", XLEN'(vstart - mon_e.acc_cyc), XLEN'(mon_e.lat));
        end
      end
    end
    prev_v = resp_valid && !resp_ready && !rst;
  end

  task automatic issue(input logic [1:0] op, input logic w, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAGW-1:0] tag, input bit track);
    exp_t e;
    int   n;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_word  = w;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
    end else if (track) begin
      e.data    = ref_mul(op, w, a, b);
      e.tag     = tag;
      e.lat     = ref_lat(w, a, b);
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish_resp(input int hold);
    int n;
    n = 0;
    while (!resp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout: resp_valid=%0b required 1", resp_valid);
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] op, input logic w, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [TAGW-1:0] tag, input int hold);
    issue(op, w, a, b, tag, 1'b1);
    finish_resp(hold);
  endtask

  initial begin
    logic seen;
    logic [XLEN-1:0] ra, rb;
    logic [1:0] rop;
    logic rw;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", XLEN'(req_ready), XLEN'(1));
    chk("rst_resp_valid", XLEN'(resp_valid), '0);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_resp_tag", XLEN'(resp_tag), '0);
    chk("rst_busy", XLEN'(busy), '0);
    chk("idle_add_a", add_a[XLEN-1:0], '0);
    chk("idle_add_b", add_b[XLEN-1:0], '0);

    do_req(2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 0);
    do_req(2'b11, 1'b0, '1, '1, 5'd2, 1);
    do_req(2'b01, 1'b0, '1, '1, 5'd3, 0);
    do_req(2'b10, 1'b0, '1, '1, 5'd4, 2);
    do_req(2'b00, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd5, 0);
    do_req(2'b01, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 5'd6, 5);
    do_req(2'b11, 1'b1, 64'hDEAD_BEEF_FFFF_FFFD, 64'd5, 5'd7, 1);

    // Flush from CALC: no response, accepting again next cycle.
    issue(2'b00, 1'b0, {$urandom, $urandom} | 64'd1, 64'd12345, 5'd9, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_req_ready", XLEN'(req_ready), XLEN'(1));
    chk("flush_busy", XLEN'(busy), '0);
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("flush_no_resp", XLEN'(seen), '0);
    do_req(2'b00, 1'b0, 64'd7, 64'd6, 5'd21, 0);

    // Flush in IDLE beats a simultaneous request.
    @(posedge clk); #1;
    flush = 1'b1;
    req_valid = 1'b1;
    req_op = 2'b00;
    req_word = 1'b0;
    req_rs1 = 64'd9;
    req_rs2 = 64'd9;
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    chk("idle_flush_ready", XLEN'(req_ready), XLEN'(1));
    chk("idle_flush_busy", XLEN'(busy), '0);

    // Asynchronous reset between edges mid-CALC.
    issue(2'b01, 1'b0, 64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_0F0F_0F0F, 5'd13, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_resp_valid", XLEN'(resp_valid), '0);
    chk("arst_req_ready", XLEN'(req_ready), XLEN'(1));
    chk("arst_busy", XLEN'(busy), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(2'b00, 1'b0, 64'd1000, 64'hFFFF_FFFF_FFFF_FF00, 5'd14, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      rw  = (rop == 2'b00) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      ra  = pick();
      rb  = pick();
      do_req(rop, rw, ra, rb, TAGW'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", XLEN'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
